// File: rtl/sdram_host_link_if.sv
// Parallel command/response and byte-link signals of the SDRAM host link.
// The master modport is the link block itself; slave is whatever drives commands and bytes.
interface sdram_host_link_if;
  logic        cmd_wr;
  logic [23:0] cmd_adr;
  logic [15:0] cmd_data;
  logic        cmd_stb;
  logic        cmd_ack;
  logic [7:0]  tx_dat;
  logic        tx_stb;
  logic        tx_ack;
  logic [7:0]  rx_dat;
  logic        rx_stb;
  logic        rx_ack;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        rsp_stb;
  logic        rsp_ack;

  modport master (
    input  cmd_wr, cmd_adr, cmd_data, cmd_stb, tx_ack, rx_dat, rx_stb, rsp_ack,
    output cmd_ack, tx_dat, tx_stb, rx_ack, rsp_data, rsp_err, rsp_stb
  );

  modport slave (
    output cmd_wr, cmd_adr, cmd_data, cmd_stb, tx_ack, rx_dat, rx_stb, rsp_ack,
    input  cmd_ack, tx_dat, tx_stb, rx_ack, rsp_data, rsp_err, rsp_stb
  );
endinterface

// File: rtl/sdram_host_link.sv
// Turns parallel SDRAM read/write commands into byte frames for the UART-side bridge
// and parses the reply bytes into one response per command, with an idle timeout.
module sdram_host_link #(
  parameter logic [7:0]  WR_OP    = 8'h57,
  parameter logic [7:0]  RD_OP    = 8'h52,
  parameter logic [7:0]  ACK_BYTE = 8'h4B,
  parameter int unsigned TO_W     = 20,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic                 CLK_133MHZ,
  input  logic                 rst,
  sdram_host_link_if.master    link,
  output logic                 busy,
  output logic [7:0]           drop_cnt
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  localparam logic [TO_W-1:0] TimeoutLast = TO_W'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [47:0]     shift_q, shift_d;
  logic [2:0]      tx_left_q, tx_left_d;
  logic [1:0]      rx_left_q, rx_left_d;
  logic            wr_q, wr_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [7:0]      drop_q, drop_d;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    tx_left_d  = tx_left_q;
    rx_left_d  = rx_left_q;
    wr_d       = wr_q;
    timer_d    = timer_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    drop_d     = drop_q;

    // Bytes arriving outside WAIT_RSP are consumed and thrown away.
    if (link.rx_stb && (state_q != StWait) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (link.cmd_stb) begin
          shift_d    = {link.cmd_wr ? WR_OP : RD_OP, link.cmd_adr,
                        link.cmd_wr ? link.cmd_data : 16'h0000};
          tx_left_d  = link.cmd_wr ? 3'd6 : 3'd4;
          wr_d       = link.cmd_wr;
          rsp_data_d = 16'h0000;
          rsp_err_d  = 1'b0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (link.tx_ack) begin
          shift_d   = {shift_q[39:0], 8'h00};
          tx_left_d = tx_left_q - 3'd1;
          if (tx_left_q == 3'd1) begin
            state_d   = StWait;
            timer_d   = '0;
            rx_left_d = wr_q ? 2'd1 : 2'd2;
          end
        end
      end
      StWait: begin
        // A byte landing on the timeout cycle takes priority over the timeout.
        if (link.rx_stb) begin
          timer_d   = '0;
          rx_left_d = rx_left_q - 2'd1;
          if (wr_q) begin
            if (link.rx_dat != ACK_BYTE) rsp_err_d = 1'b1;
          end else begin
            rsp_data_d = {rsp_data_q[7:0], link.rx_dat};
          end
          if (rx_left_q == 2'd1) state_d = StResp;
        end else if (timer_q == TimeoutLast) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = 16'h0000;
          state_d    = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        if (link.rsp_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_133MHZ or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      tx_left_q  <= '0;
      rx_left_q  <= '0;
      wr_q       <= 1'b0;
      timer_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      tx_left_q  <= tx_left_d;
      rx_left_q  <= rx_left_d;
      wr_q       <= wr_d;
      timer_q    <= timer_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    link.cmd_ack  = (state_q == StIdle);
    link.tx_stb   = (state_q == StSend);
    link.tx_dat   = (state_q == StSend) ? shift_q[47:40] : 8'h00;
    // Every state consumes rx bytes; only reset itself holds rx_ack low.
    link.rx_ack   = ~rst;
    link.rsp_stb  = (state_q == StResp);
    link.rsp_data = rsp_data_q;
    link.rsp_err  = rsp_err_q;
    busy          = (state_q != StIdle);
    drop_cnt      = drop_q;
  end

endmodule

// File: tb/tb_sdram_host_link.sv
// Directed bench for sdram_host_link: a table of full transactions plus hand-written
// sequences for tx back-pressure, timeout edges, stray bytes and mid-frame reset.
module tb_sdram_host_link;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  sdram_host_link_if link ();

  sdram_host_link #(
    .TIMEOUT (16)
  ) dut (
    .CLK_133MHZ (clk),
    .rst        (rst),
    .link       (link),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  typedef struct {
    logic        wr;
    logic [23:0] adr;
    logic [15:0] data;
    logic [7:0]  rx0;
    logic [7:0]  rx1;
    logic [47:0] exp_tx;
    int          exp_ntx;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Accept a command and push all its bytes with tx_ack held high.
  task automatic send_cmd(input logic wr, input logic [23:0] adr, input logic [15:0] data);
    link.cmd_wr   = wr;
    link.cmd_adr  = adr;
    link.cmd_data = data;
    link.cmd_stb  = 1'b1;
    link.tx_ack   = 1'b1;
    step;
    link.cmd_stb = 1'b0;
    for (int k = 0; k < (wr ? 6 : 4); k++) step;
  endtask

  task automatic drain_rsp(input string tag);
    link.rsp_ack = 1'b1;
    step;
    link.rsp_ack = 1'b0;
    check({tag, " cmd_ack back"}, 48'(link.cmd_ack), 48'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    check({tag, " idle"}, 48'(link.cmd_ack), 48'd1);
    link.cmd_wr   = v.wr;
    link.cmd_adr  = v.adr;
    link.cmd_data = v.data;
    link.cmd_stb  = 1'b1;
    link.tx_ack   = 1'b1;
    step;
    link.cmd_stb = 1'b0;
    for (int k = 0; k < v.exp_ntx; k++) begin
      check({tag, " tx_stb"}, 48'(link.tx_stb), 48'd1);
      check({tag, " tx_dat"}, 48'(link.tx_dat), 48'(v.exp_tx[47-8*k -: 8]));
      step;
    end
    check({tag, " tx done"}, 48'(link.tx_stb), 48'd0);
    link.rx_dat = v.rx0;
    link.rx_stb = 1'b1;
    step;
    if (!v.wr) begin
      link.rx_dat = v.rx1;
      step;
    end
    link.rx_stb = 1'b0;
    check({tag, " rsp_stb"}, 48'(link.rsp_stb), 48'd1);
    check({tag, " rsp_data"}, 48'(link.rsp_data), 48'(v.exp_data));
    check({tag, " rsp_err"}, 48'(link.rsp_err), 48'(v.exp_err));
    drain_rsp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] exp_tx;
    int          idx;
    int          early;

    vecs[0] = '{1'b1, 24'h123456, 16'hBEEF, 8'h4B, 8'h00, 48'h57123456BEEF, 6, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 24'h000010, 16'h0000, 8'hCA, 8'hFE, 48'h520000100000, 4, 16'hCAFE, 1'b0};
    vecs[2] = '{1'b1, 24'h000001, 16'h0000, 8'h00, 8'h00, 48'h570000010000, 6, 16'h0000, 1'b1};
    vecs[3] = '{1'b0, 24'hFFFFFF, 16'h9999, 8'h12, 8'h34, 48'h52FFFFFF0000, 4, 16'h1234, 1'b0};
    vecs[4] = '{1'b1, 24'hABCDEF, 16'h55AA, 8'h4B, 8'h00, 48'h57ABCDEF55AA, 6, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 24'h800000, 16'h0001, 8'h4A, 8'h00, 48'h578000000001, 6, 16'h0000, 1'b1};

    rst           = 1'b1;
    link.cmd_wr   = 1'b0;
    link.cmd_adr  = '0;
    link.cmd_data = '0;
    link.cmd_stb  = 1'b0;
    link.tx_ack   = 1'b0;
    link.rx_dat   = '0;
    link.rx_stb   = 1'b0;
    link.rsp_ack  = 1'b0;
    step;
    step;
    check("reset cmd_ack", 48'(link.cmd_ack), 48'd1);
    check("reset tx_stb", 48'(link.tx_stb), 48'd0);
    check("reset rx_ack", 48'(link.rx_ack), 48'd0);
    check("reset rsp_stb", 48'(link.rsp_stb), 48'd0);
    check("reset busy", 48'(busy), 48'd0);
    check("reset drop_cnt", 48'(drop_cnt), 48'd0);
    rst = 1'b0;
    #1;
    check("post-reset rx_ack", 48'(link.rx_ack), 48'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // tx_ack toggling: each byte must appear once and hold until acked.
    exp_tx = 48'h570F0E0DA5C3;
    link.cmd_wr   = 1'b1;
    link.cmd_adr  = 24'h0F0E0D;
    link.cmd_data = 16'hA5C3;
    link.cmd_stb  = 1'b1;
    link.tx_ack   = 1'b0;
    step;
    link.cmd_stb = 1'b0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (!link.tx_stb || idx > 5) break;
      check("toggle tx_dat", 48'(link.tx_dat), 48'(exp_tx[47-8*idx -: 8]));
      link.tx_ack = (c % 2 == 1);
      step;
      if (link.tx_ack) idx++;
    end
    link.tx_ack = 1'b1;
    check("toggle byte count", 48'(idx), 48'd6);
    check("toggle tx done", 48'(link.tx_stb), 48'd0);
    link.rx_dat = 8'h4B;
    link.rx_stb = 1'b1;
    step;
    link.rx_stb = 1'b0;
    check("toggle rsp_err", 48'(link.rsp_err), 48'd0);
    drain_rsp("toggle");

    // Read with silence: response exactly 16 cycles after entering WAIT_RSP.
    send_cmd(1'b0, 24'h000020, 16'h0000);
    early = 0;
    for (int c = 0; c < 15; c++) begin
      step;
      if (link.rsp_stb) early++;
    end
    check("timeout early rsp_stb", 48'(early), 48'd0);
    step;
    check("timeout rsp_stb", 48'(link.rsp_stb), 48'd1);
    check("timeout rsp_err", 48'(link.rsp_err), 48'd1);
    check("timeout rsp_data", 48'(link.rsp_data), 48'd0);
    drain_rsp("timeout");

    // One byte then silence: timer restarts from that byte, partial data discarded.
    send_cmd(1'b0, 24'h000030, 16'h0000);
    link.rx_dat = 8'hAB;
    link.rx_stb = 1'b1;
    step;
    link.rx_stb = 1'b0;
    early = 0;
    for (int c = 0; c < 15; c++) begin
      step;
      if (link.rsp_stb) early++;
    end
    check("partial early rsp_stb", 48'(early), 48'd0);
    step;
    check("partial rsp_stb", 48'(link.rsp_stb), 48'd1);
    check("partial rsp_err", 48'(link.rsp_err), 48'd1);
    check("partial rsp_data", 48'(link.rsp_data), 48'd0);
    drain_rsp("partial");

    // Final byte on the timeout cycle: the byte wins.
    send_cmd(1'b0, 24'h000040, 16'h0000);
    link.rx_dat = 8'hAB;
    link.rx_stb = 1'b1;
    step;
    link.rx_stb = 1'b0;
    for (int c = 0; c < 15; c++) step;
    check("race not yet done", 48'(link.rsp_stb), 48'd0);
    link.rx_dat = 8'hCD;
    link.rx_stb = 1'b1;
    step;
    link.rx_stb = 1'b0;
    check("race rsp_stb", 48'(link.rsp_stb), 48'd1);
    check("race rsp_err", 48'(link.rsp_err), 48'd0);
    check("race rsp_data", 48'(link.rsp_data), 48'hABCD);
    drain_rsp("race");

    // Stray bytes in IDLE.
    link.rx_dat = 8'h11;
    link.rx_stb = 1'b1;
    for (int c = 0; c < 3; c++) step;
    link.rx_stb = 1'b0;
    check("drop_cnt 3", 48'(drop_cnt), 48'd3);
    check("stray busy", 48'(busy), 48'd0);
    link.rx_stb = 1'b1;
    for (int c = 0; c < 297; c++) step;
    link.rx_stb = 1'b0;
    check("drop_cnt saturate", 48'(drop_cnt), 48'd255);

    // Reset after two bytes of a write frame.
    link.cmd_wr   = 1'b1;
    link.cmd_adr  = 24'h777777;
    link.cmd_data = 16'h1234;
    link.cmd_stb  = 1'b1;
    link.tx_ack   = 1'b1;
    step;
    link.cmd_stb = 1'b0;
    step;
    step;
    check("pre-rst tx_dat", 48'(link.tx_dat), 48'h77);
    rst = 1'b1;
    #1;
    check("mid-rst cmd_ack", 48'(link.cmd_ack), 48'd1);
    check("mid-rst tx_stb", 48'(link.tx_stb), 48'd0);
    check("mid-rst tx_dat", 48'(link.tx_dat), 48'd0);
    check("mid-rst rx_ack", 48'(link.rx_ack), 48'd0);
    check("mid-rst rsp_stb", 48'(link.rsp_stb), 48'd0);
    check("mid-rst rsp_data", 48'(link.rsp_data), 48'd0);
    check("mid-rst rsp_err", 48'(link.rsp_err), 48'd0);
    check("mid-rst busy", 48'(busy), 48'd0);
    check("mid-rst drop_cnt", 48'(drop_cnt), 48'd0);
    link.cmd_stb = 1'b1;
    step;
    link.cmd_stb = 1'b0;
    check("rst ignores cmd", 48'(busy), 48'd0);
    rst = 1'b0;
    #1;
    run_vec(vecs[0], "after-rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_host_link.md
# sdram_host_link

Command initiator for the byte-stream SDRAM access protocol. It turns parallel read and write requests into the command bytes consumed by the UART-side SDRAM bridge. It then collects the response bytes and returns one parsed response per command, with a timeout. It sits on the host side of the byte link, so test masters and loopback benches can drive SDRAM traffic without hand-building frames.

## Interface
Parameters:
- WR_OP, 8'h57: opcode byte for a write command.
- RD_OP, 8'h52: opcode byte for a read command.
- ACK_BYTE, 8'h4B: byte expected as the write acknowledge.
- TO_W, 20: timeout counter width.
- TIMEOUT, 1000000: idle cycles allowed between response bytes; must be < 2^TO_W.

Ports:
- CLK_133MHZ  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_adr  in  24  SDRAM word address.
- cmd_data  in  16  write data; ignored for reads.
- cmd_stb  in  1  command valid.
- cmd_ack  out  1  command accepted (ready).
- tx_dat  out  8  command byte to the link.
- tx_stb  out  1  tx_dat valid.
- tx_ack  in  1  link accepted the byte.
- rx_dat  in  8  response byte from the link.
- rx_stb  in  1  rx_dat valid.
- rx_ack  out  1  response byte consumed.
- rsp_data  out  16  read data; 0 for writes and on timeout.
- rsp_err  out  1  timeout, or wrong write acknowledge byte.
- rsp_stb  out  1  response valid.
- rsp_ack  in  1  response consumer ready.
- busy  out  1  state != IDLE.
- drop_cnt  out  8  count of unexpected rx bytes discarded; saturates at 255.

## Operation
- Handshake rule: a transfer occurs on every rising edge where stb and ack are both high. A stb, once raised, stays high with stable data until acked.
- State machine: IDLE, SEND, WAIT_RSP, RESP.
- IDLE:
  - cmd_ack = 1.
  - On cmd_stb & cmd_ack, latch a 48-bit shift register {op, adr[23:16], adr[15:8], adr[7:0], data[15:8], data[7:0]}.
  - Set byte count to 6 (write) or 4 (read), then go to SEND.
- SEND:
  - tx_stb = 1; tx_dat = shift[47:40].
  - On tx_ack: shift left 8 and decrement the count.
  - When the last byte is acked, go to WAIT_RSP, clear the timer, and set expected rx bytes to 2 (read) or 1 (write).
- WAIT_RSP:
  - rx_ack = 1.
  - Read: accepted bytes are shifted into rsp_data, MSB first.
  - Write: the single byte is compared with ACK_BYTE; a mismatch sets rsp_err = 1.
  - The timer increments every cycle and clears on each accepted byte.
  - After the last expected byte, go to RESP.
  - If the timer reaches TIMEOUT-1 first: rsp_err = 1, rsp_data = 0, go to RESP.
- RESP:
  - rsp_stb = 1; on rsp_ack go to IDLE.
  - rsp_data and rsp_err are cleared on the next command accept.
- Unexpected rx bytes (received in IDLE, SEND or RESP): rx_ack = 1, the byte is discarded and drop_cnt increments, saturating at 255.
- cmd_ack, tx_stb, rx_ack, rsp_stb and busy are decoded from state only, never from the input strobes.

## Timing
- Reset values:
  - State = IDLE; cmd_ack = 1 in IDLE.
  - All other outputs are 0: tx_stb, tx_dat, rx_ack, rsp_stb, rsp_data, rsp_err, busy, drop_cnt.
  - Handshakes during rst are ignored.
- Command accepted at cycle N: tx_stb is high from N+1.
- With tx_ack held high, bytes transfer at N+1..N+6 (write) or N+1..N+4 (read). WAIT_RSP begins the next cycle.
- Final response byte accepted at cycle M: rsp_stb high at M+1.
- With rsp_ack held high, cmd_ack is back at 1 at M+2.
- Timeout fires exactly TIMEOUT cycles after entering WAIT_RSP or after the last accepted byte.
- Final byte and timeout in the same cycle: the byte wins and rsp_err = 0.
- rst mid-operation: immediate return to IDLE; any partial frame is abandoned, not resumed.

## Test plan
- Write adr 24'h123456, data 16'hBEEF, tx_ack = 1 -> tx bytes 57,12,34,56,BE,EF on consecutive cycles; rx 4B -> rsp_stb with rsp_err = 0, rsp_data = 0.
- Read adr 24'h000010, rx bytes CA,FE -> tx bytes 52,00,00,10; rsp_data = 16'hCAFE, rsp_err = 0.
- tx_ack toggling 1/0 during a write -> no byte duplicated or skipped; tx_dat stable while unacked.
- TIMEOUT = 16, read with no rx bytes -> rsp_stb exactly 16 cycles after entering WAIT_RSP, rsp_err = 1, rsp_data = 0.
- Write answered with 8'h00 -> rsp_err = 1. Three stray rx bytes in IDLE -> drop_cnt = 3; 300 stray bytes -> drop_cnt = 255.
- rst asserted during SEND after 2 bytes -> all outputs at reset values; the next command restarts at its opcode byte.
